// File: rtl/display_mux_7seg.sv
// Two-digit multiplexed 7-segment driver for the minute/second counter.
// Converts the binary count to BCD one shift-add-3 step per clock, then scans tens/units.
module display_mux_7seg #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int CARRY_HOLD     = 25000000,
  parameter int BLANK_LEADING  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] valoare_bin,
  input  logic       carry_out,
  input  logic       pause,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int HW = $clog2(CARRY_HOLD + 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CARRY_HOLD);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t      state, state_next;
  logic [5:0]  last_val, conv_val, shift_reg;
  logic [7:0]  bcd, bcd_adj;
  logic [13:0] shifted;
  logic [2:0]  iter;
  logic [3:0]  tens, units;
  logic [RW-1:0] refresh_cnt;
  logic [HW-1:0] hold_cnt;
  logic        sel_tens;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign bcd_adj   = {add3(bcd[7:4]), add3(bcd[3:0])};
  assign shifted   = {bcd_adj, shift_reg} << 1;
  assign conv_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valoare_bin != last_val) state_next = CONV;
      CONV:    if (iter == 3'd5) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // last_val only moves in LOAD, so inputs that change mid-conversion are picked up afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      tens      <= '0;
      units     <= '0;
      last_val  <= '0;
      conv_val  <= '0;
      shift_reg <= '0;
      bcd       <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valoare_bin != last_val) begin
            conv_val  <= valoare_bin;
            shift_reg <= valoare_bin;
            bcd       <= '0;
            iter      <= '0;
          end
        end
        CONV: begin
          {bcd, shift_reg} <= shifted;
          iter             <= iter + 3'd1;
        end
        LOAD: begin
          tens     <= bcd[7:4];
          units    <= bcd[3:0];
          last_val <= conv_val;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      sel_tens    <= 1'b0;
      hold_cnt    <= '0;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      an          <= 4'b1111;
    end else begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        sel_tens    <= ~sel_tens;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end

      if (carry_out)           hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);

      if (sel_tens) begin
        an  <= 4'b1101;
        seg <= (BLANK_LEADING != 0 && tens == 4'd0) ? 7'b1111111 : decode(tens);
        dp  <= (hold_cnt == '0);
      end else begin
        an  <= 4'b1110;
        seg <= decode(units);
        dp  <= ~pause;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Bench for display_mux_7seg: directed scenarios plus random traffic against a
// timing-level reference model (value/10, value%10, scan phase from cycle count).
module tb_display_mux_7seg;

  localparam int R  = 4;
  localparam int CH = 10;
  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] valoare_bin;
  logic       carry_out;
  logic       pause;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_busy;

  int n_checks = 0;
  int n_fail   = 0;

  int  m_cyc, m_last_carry, m_tens, m_units, m_last, m_conv_start, m_conv_val;
  bit  m_have_carry, m_conv;
  logic [6:0] e_seg;
  logic       e_dp, e_busy;
  logic [3:0] e_an;

  display_mux_7seg #(.REFRESH_CYCLES(R), .CARRY_HOLD(CH), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .valoare_bin(valoare_bin), .carry_out(carry_out),
    .pause(pause), .seg(seg), .dp(dp), .an(an), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  // Reference: display outputs use pre-edge model state, then the edge's inputs update it
  function automatic void model_edge();
    int sel;
    if (reset) begin
      e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111; e_busy = 1'b0;
      m_cyc = 0; m_have_carry = 0; m_tens = 0; m_units = 0; m_last = 0; m_conv = 0;
    end else begin
      sel = (m_cyc / R) % 2;
      if (sel == 1) begin
        e_an  = 4'b1101;
        e_seg = (m_tens == 0) ? 7'b1111111 : SEG_TAB[m_tens];
        e_dp  = !(m_have_carry && (m_cyc - m_last_carry) <= CH);
      end else begin
        e_an  = 4'b1110;
        e_seg = SEG_TAB[m_units];
        e_dp  = !pause;
      end
      if (carry_out) begin
        m_have_carry = 1;
        m_last_carry = m_cyc;
      end
      if (m_conv && m_cyc == m_conv_start + 7) begin
        m_tens  = m_conv_val / 10;
        m_units = m_conv_val % 10;
        m_last  = m_conv_val;
        m_conv  = 0;
      end else if (!m_conv && int'(valoare_bin) != m_last) begin
        m_conv       = 1;
        m_conv_start = m_cyc;
        m_conv_val   = int'(valoare_bin);
      end
      e_busy = m_conv;
      m_cyc++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] v, input logic c, input logic p);
    valoare_bin = v;
    carry_out   = c;
    pause       = p;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL reset_values: seg=%b dp=%b an=%b busy=%b expected 1111111 1 1111 0",
                 seg, dp, an, conv_busy);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4 * R; i++) begin
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL reset_scan[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
      if (i == 0) begin
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b1000000}) begin
          n_fail++;
          $display("[TB] FAIL first_units: an=%b seg=%b expected 1110 1000000", an, seg);
        end
      end
      if (i == R) begin
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'b1111111}) begin
          n_fail++;
          $display("[TB] FAIL blank_tens: an=%b seg=%b expected 1101 1111111", an, seg);
        end
      end
    end
  endtask

  task automatic test_conversion_47();
    applyStimulus(6'd47, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (conv_busy !== (i <= 6)) begin
        n_fail++;
        $display("[TB] FAIL busy_47[%0d]: busy=%b expected %b", i, conv_busy, (i <= 6));
      end
    end
    for (int i = 0; i < 4 * R; i++) begin
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL conv_47[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
      n_checks++;
      if (seg !== ((e_an == 4'b1110) ? 7'b1111000 : 7'b0011001)) begin
        n_fail++;
        $display("[TB] FAIL digits_47[%0d]: seg=%b an_expected=%b", i, seg, e_an);
      end
    end
  endtask

  task automatic test_change_during_conv();
    applyStimulus(6'd59, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 1) valoare_bin = 6'd23;
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL change_mid_conv[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
      if (i >= 18) begin
        n_checks++;
        if (seg !== ((e_an == 4'b1110) ? 7'b0110000 : 7'b0100100)) begin
          n_fail++;
          $display("[TB] FAIL digits_23[%0d]: seg=%b an_expected=%b", i, seg, e_an);
        end
      end
    end
  endtask

  task automatic test_max_value();
    applyStimulus(6'd63, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL max_63[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
      if (i >= 9) begin
        n_checks++;
        if (seg !== ((e_an == 4'b1110) ? 7'b0110000 : 7'b0000010)) begin
          n_fail++;
          $display("[TB] FAIL digits_63[%0d]: seg=%b an_expected=%b", i, seg, e_an);
        end
      end
    end
  endtask

  task automatic test_dp();
    pause = 1'b1;
    for (int i = 0; i < 2 * R; i++) begin
      step();
      n_checks++;
      if (dp !== (e_an == 4'b1110 ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL pause_dp[%0d]: dp=%b an_expected=%b", i, dp, e_an);
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 30; i++) begin
      carry_out = (i == 0 || i == 5);
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL carry_dp[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
      if (e_an == 4'b1101) begin
        n_checks++;
        if (dp !== ((i >= 1 && i <= 15) ? 1'b0 : 1'b1)) begin
          n_fail++;
          $display("[TB] FAIL carry_window[%0d]: dp=%b expected %b", i, dp, !(i >= 1 && i <= 15));
        end
      end
    end
    carry_out = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    applyStimulus(6'd38, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({seg, dp, an, conv_busy} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_conv: seg=%b dp=%b an=%b busy=%b expected 1111111 1 1111 0",
               seg, dp, an, conv_busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL reconv_38[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
      if (i >= 8) begin
        n_checks++;
        if (seg !== ((e_an == 4'b1110) ? 7'b0000000 : 7'b0110000)) begin
          n_fail++;
          $display("[TB] FAIL digits_38[%0d]: seg=%b an_expected=%b", i, seg, e_an);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(11) == 0) valoare_bin = 6'($urandom_range(63));
      carry_out = ($urandom_range(19) == 0);
      if ($urandom_range(29) == 0) pause = ~pause;
      reset = ($urandom_range(149) == 0);
      step();
      n_checks++;
      if ({seg, dp, an, conv_busy} !== {e_seg, e_dp, e_an, e_busy}) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: seg=%b dp=%b an=%b busy=%b expected %b %b %b %b",
                 i, seg, dp, an, conv_busy, e_seg, e_dp, e_an, e_busy);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(6'd0, 1'b0, 1'b0);
    test_reset();
    test_conversion_47();
    test_change_during_conv();
    test_max_value();
    test_dp();
    test_reset_mid_conv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
